// File: rtl/pipe_id_regbypass.sv
// Decode-stage operand unit: GPR file, EX/MEM/WB forwarding, load-use
// hazard detection and the ID/EX operand latch with valid/ready and flush.
module pipe_id_regbypass #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned FWD_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          use1,
  input  logic          use2,
  input  logic [AW-1:0] ex_wa,
  input  logic          ex_wen,
  input  logic          ex_load,
  input  logic [DW-1:0] ex_wd,
  input  logic [AW-1:0] mem_wa,
  input  logic          mem_wen,
  input  logic [DW-1:0] mem_wd,
  input  logic [AW-1:0] wb_wa,
  input  logic          wb_wen,
  input  logic [DW-1:0] wb_wd,
  input  logic          wb_ovf,
  input  logic          flush,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          stall
);

  localparam bit FWD = (FWD_EN != 0);

  logic [DW-1:0] regs [NREG];
  logic          wb_commit;
  logic          hz;
  logic          adv;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  // Resolve one source operand: r0, then youngest in-flight producer first.
  function automatic logic [DW-1:0] sel_operand(input logic [AW-1:0] a);
    logic [DW-1:0] val;
    val = '0;
    if (a == '0) begin
      val = '0;
    end else if (FWD && ex_wen && (ex_wa == a) && !ex_load) begin
      val = ex_wd;
    end else if (FWD && mem_wen && (mem_wa == a)) begin
      val = mem_wd;
    end else if (wb_wen && !wb_ovf && (wb_wa == a)) begin
      val = wb_wd;
    end else if (32'(a) < NREG) begin
      val = regs[a];
    end
    return val;
  endfunction

  // Per-port hazard: load-use with forwarding, any EX/MEM producer without.
  function automatic logic port_hz(input logic [AW-1:0] a, input logic u);
    logic ex_hit;
    logic mem_hit;
    ex_hit  = ex_wen && (ex_wa == a);
    mem_hit = mem_wen && (mem_wa == a);
    if (!u || (a == '0)) begin
      return 1'b0;
    end else if (FWD) begin
      return ex_hit && ex_load;
    end else begin
      return ex_hit || mem_hit;
    end
  endfunction

  // Operand selection, hazard and handshake terms.
  always_comb begin
    wb_commit = wb_wen && !wb_ovf && (wb_wa != '0) && (32'(wb_wa) < NREG);
    op1       = sel_operand(ra1);
    op2       = sel_operand(ra2);
    hz        = id_valid && (port_hz(ra1, use1) || port_hz(ra2, use2));
    adv       = !ex_valid || ex_ready;
    id_ready  = adv && !hz && !flush;
    stall     = id_valid && (hz || !adv);
  end

  // Register file write from WB; r0 stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_commit) begin
      regs[wb_wa] <= wb_wd;
    end
  end

  // ID/EX latch: flush kills, hazard inserts a bubble, backpressure holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      rd1      <= '0;
      rd2      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid <= id_valid && !hz;
      rd1      <= op1;
      rd2      <= op2;
    end
  end

endmodule
